// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART command controller: FSM encoding, header layout,
// sync default and error-counter ceiling.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    POP_HDR  = 3'd1,
    WAIT_HDR = 3'd2,
    DECODE   = 3'd3,
    POP_DAT  = 3'd4,
    WAIT_DAT = 3'd5,
    WRITE    = 3'd6,
    READ_TX  = 3'd7
  } state_t;

  localparam logic [3:0] SYNC_DEFAULT = 4'hA;

  localparam int HDR_SYNC_MSB = 7;
  localparam int HDR_SYNC_LSB = 4;
  localparam int HDR_RD_BIT   = 3;
  localparam int HDR_RSV_BIT  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // A header is usable when its sync nibble matches and the reserved bit is clear.
  function automatic logic hdr_valid(input logic [7:0] hdr, input logic [3:0] sync);
    return (hdr[HDR_SYNC_MSB:HDR_SYNC_LSB] == sync) && !hdr[HDR_RSV_BIT];
  endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// FIFO-side signals of the command controller: pop port of the Rx FIFO and push port
// of the Tx FIFO.
interface uart_rx_cmd_ctrl_if;
  // Handshake: NxT pops one Rx byte per high cycle and is only raised while Rx_EMPTY=0;
  // the popped byte is valid on I_DATA two edges later. Tx_WR pushes Tx_DATA for one
  // cycle and is only raised while Tx_FULL=0.
  logic [7:0] I_DATA;
  logic       Rx_EMPTY;
  logic       NxT;
  logic       Tx_FULL;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;

  modport master (
    input  I_DATA, Rx_EMPTY, Tx_FULL,
    output NxT, Tx_DATA, Tx_WR
  );

  modport slave (
    output I_DATA, Rx_EMPTY, Tx_FULL,
    input  NxT, Tx_DATA, Tx_WR
  );
endinterface

// File: rtl/uart_timeout.sv
// Inter-byte timeout counter: counts enabled cycles after a clear and flags expiry on
// the TIMEOUT-th enabled cycle.
module uart_timeout #(
  parameter int TIMEOUT = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Holds at TIMEOUT-1 so expiry stays asserted until the next clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Parses header/data frames from the UART Rx FIFO into four config registers and
// answers read frames by pushing the addressed register into the UART Tx FIFO.
module uart_rx_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int         TIMEOUT = 20000,
  parameter logic [3:0] SYNC    = SYNC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_rx_cmd_ctrl_if.master         bus,
  output logic [31:0]                CFG,
  output logic                       CFG_STB,
  output logic [1:0]                 CFG_ADDR,
  output logic [7:0]                 ERR_CNT,
  output state_t                     dbg_state
);

  state_t          state_q, state_d;
  logic            wait_q;
  logic [7:0]      hdr_q;
  logic [7:0]      dat_q;
  logic [3:0][7:0] cfg_q;
  logic [1:0]      cfg_addr_q;
  logic [7:0]      err_q;

  logic       nxt;
  logic       tx_wr;
  logic       cfg_stb;
  logic       err_inc;
  logic       to_clear;
  logic       to_en;
  logic       to_expired;
  logic [1:0] addr;

  assign addr = hdr_q[HDR_ADDR_MSB:HDR_ADDR_LSB];

  uart_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_clear),
    .enable  (to_en),
    .expired (to_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_q     <= 1'b0;
      hdr_q      <= '0;
      dat_q      <= '0;
      cfg_q      <= '0;
      cfg_addr_q <= '0;
      err_q      <= '0;
    end else begin
      state_q <= state_d;
      // wait_q marks the second cycle of a WAIT state, when the popped byte is valid.
      wait_q  <= ((state_q == WAIT_HDR) || (state_q == WAIT_DAT)) ? ~wait_q : 1'b0;
      if ((state_q == WAIT_HDR) && wait_q) hdr_q <= bus.I_DATA;
      if ((state_q == WAIT_DAT) && wait_q) dat_q <= bus.I_DATA;
      if (state_q == WRITE) begin
        cfg_q[addr] <= dat_q;
        cfg_addr_q  <= addr;
      end
      if (err_inc && (err_q != ERR_CNT_MAX)) err_q <= err_q + 8'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    nxt      = 1'b0;
    tx_wr    = 1'b0;
    cfg_stb  = 1'b0;
    err_inc  = 1'b0;
    to_clear = 1'b0;
    to_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.Rx_EMPTY) state_d = POP_HDR;
      end
      POP_HDR: begin
        if (!bus.Rx_EMPTY) begin
          nxt     = 1'b1;
          state_d = WAIT_HDR;
        end
      end
      WAIT_HDR: begin
        if (wait_q) state_d = DECODE;
      end
      DECODE: begin
        to_clear = 1'b1;
        if (!hdr_valid(hdr_q, SYNC)) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else if (hdr_q[HDR_RD_BIT]) begin
          state_d = READ_TX;
        end else begin
          state_d = POP_DAT;
        end
      end
      POP_DAT: begin
        if (!bus.Rx_EMPTY) begin
          nxt     = 1'b1;
          state_d = WAIT_DAT;
        end else begin
          to_en = 1'b1;
          if (to_expired) begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DAT: begin
        if (wait_q) state_d = WRITE;
      end
      WRITE: begin
        cfg_stb = 1'b1;
        state_d = IDLE;
      end
      READ_TX: begin
        if (!bus.Tx_FULL) begin
          tx_wr   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.NxT     = nxt;
  assign bus.Tx_WR   = tx_wr;
  assign bus.Tx_DATA = tx_wr ? cfg_q[addr] : 8'h00;
  assign CFG         = cfg_q;
  assign CFG_STB     = cfg_stb;
  // During the write cycle the strobe and its address appear together.
  assign CFG_ADDR    = cfg_stb ? addr : cfg_addr_q;
  assign ERR_CNT     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/uart_rx_cmd_ctrl.md
UART_RX_CMD_CTRL -- requirements
Module: uart_rx_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 20000: the data byte of a write frame must arrive within this many clk cycles, measured from header decode.
REQ-002 Parameter SYNC, default 4'hA: required value of header bits [7:4].
REQ-003 clk  input  1  system clock; the block uses this single clock domain only.
REQ-004 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-005 I_DATA  input  8  byte output of the UART_Rx FIFO.
REQ-006 Rx_EMPTY  input  1  UART_Rx FIFO is empty.
REQ-007 NxT  output  1  one-cycle pop strobe to the UART_Rx FIFO.
REQ-008 Tx_FULL  input  1  UART_Tx FIFO is full.
REQ-009 Tx_DATA  output  8  readback byte sent to the UART_Tx FIFO.
REQ-010 Tx_WR  output  1  one-cycle push strobe to the UART_Tx FIFO.
REQ-011 CFG  output  32  four 8-bit configuration registers; reg n occupies CFG[8n+7:8n].
REQ-012 CFG_STB  output  1  one-cycle pulse after any register write.
REQ-013 CFG_ADDR  output  2  index of the last register written.
REQ-014 ERR_CNT  output  8  saturating count of bad headers and timeouts.

Function
REQ-015 Header byte format: [7:4] = SYNC, [3] = 1 for read / 0 for write, [2] = 0, [1:0] = register address.
REQ-016 Write frame: header byte followed by one data byte; the data byte is stored to CFG[addr].
REQ-017 Read frame: header byte only; the value of CFG[addr] is pushed once to Tx.
REQ-018 FSM states are IDLE, POP_HDR, WAIT_HDR, DECODE, POP_DAT, WAIT_DAT, WRITE and READ_TX.
REQ-019 Pop handshake: in a POP state, NxT is high for exactly one cycle and only when Rx_EMPTY=0; I_DATA is sampled on the 2nd rising edge after that NxT edge (the WAIT state lasts 2 cycles).
REQ-020 IDLE -> POP_HDR when Rx_EMPTY=0; POP_HDR -> WAIT_HDR; WAIT_HDR -> DECODE.
REQ-021 DECODE on a bad header ([7:4] != SYNC or [2]=1): ERR_CNT increments and the FSM returns to IDLE; the bad byte is discarded and no resync search is performed.
REQ-022 DECODE on a valid write -> POP_DAT; on a valid read -> READ_TX.
REQ-023 POP_DAT waits while Rx_EMPTY=1; if the wait reaches TIMEOUT cycles, ERR_CNT increments and the FSM returns to IDLE with no write.
REQ-024 WRITE updates CFG[addr] and pulses CFG_STB with CFG_ADDR=addr in the same cycle; the new CFG value is visible on the next edge, and the FSM then returns to IDLE.
REQ-025 READ_TX holds while Tx_FULL=1; when Tx_FULL=0 it drives Tx_WR high for one cycle with Tx_DATA=CFG[addr] and returns to IDLE.
REQ-026 ERR_CNT saturates at 8'hFF; it never wraps.
REQ-027 Back-to-back frames: the FSM is never more than 1 cycle in IDLE when Rx_EMPTY=0.
REQ-028 A read of an address on the same frame boundary as a preceding write to it returns the newly written value.
REQ-029 Minimum frame latency: a write frame takes 8 cycles from leaving IDLE to CFG_STB when both bytes are already queued.

Reset
REQ-030 When rst=0, the block asynchronously clears FSM -> IDLE, CFG = 0, CFG_ADDR = 0, ERR_CNT = 0, NxT = 0, Tx_WR = 0, Tx_DATA = 0, CFG_STB = 0, and the timeout counter to 0.
REQ-031 Reset mid-frame abandons the frame; a byte already popped is lost, and bytes still in the FIFO are parsed as headers after release.
REQ-032 Reset is released asynchronously; the first FSM transition occurs on the 1st clk edge after rst rises.

Structure
REQ-033 Shared package uart_ctrl_pkg holds the state encoding, the SYNC default, the header bit-field positions, and ERR_CNT_MAX.
REQ-034 The inter-byte timeout counter is one sub-module, uart_timeout (inputs: clear, enable; output: expired), with a width derived from TIMEOUT.
REQ-035 The block instantiates no FIFO; the existing UART_Rx and UART_Tx FIFOs are used.

Verification
REQ-036 Queue A1,5C -> CFG[15:8]=0x5C, one CFG_STB with CFG_ADDR=1, ERR_CNT=0.
REQ-037 Write A2,3F then queue AA -> Tx_WR once with Tx_DATA=0x3F; with Tx_FULL held high for 10 cycles, Tx_WR fires only after it drops.
REQ-038 Queue 55, then A0,11 -> ERR_CNT=1, CFG[7:0]=0x11 (the bad byte is skipped).
REQ-039 Queue A3 only and hold Rx_EMPTY=1 for TIMEOUT cycles -> ERR_CNT=1, no CFG_STB; a later A3,77 gives CFG[31:24]=0x77.
REQ-040 Pulse rst=0 between the A0 header and its data byte -> all outputs are 0 immediately; the data byte is then treated as a header and counted as an error if invalid.
REQ-041 Send 260 bad headers -> ERR_CNT=0xFF; NxT is never asserted while Rx_EMPTY=1.
